// File: rtl/clock_div_stage.sv
// rtl/clock_div_stage.sv - single divide-by-two toggle flop
//
// Purpose: one bit of the power-of-two divider chain. The flop flips on a
// clk_in rising edge whenever toggle_en is high, and clears at once on reset.
// Ports:
//   clk_in    - source clock, rising edge active
//   rst       - asynchronous active-low reset, clears q
//   toggle_en - when 1, q inverts on the next clk_in rising edge
//   q         - registered stage output
module clock_div_stage (
  input  logic clk_in,
  input  logic rst,
  input  logic toggle_en,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_q <= 1'b0;
    end else if (toggle_en) begin
      r_q <= ~r_q;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/clock_div_two.sv
// rtl/clock_div_two.sv - phase-aligned /2 /4 /8 /16 clock divider
//
// Purpose: four divided clocks built as a synchronous 4-bit up-counter made
// of toggle flops. Every output is a flop output clocked by clk_in, so all
// outputs change on the same clk_in rising edge with no ripple skew.
// Ports:
//   clk_in     - source clock, rising edge active
//   rst        - asynchronous active-low reset; all outputs 0 while low
//   clk_div_2  - clk_in / 2,  50% duty
//   clk_div_4  - clk_in / 4,  50% duty
//   clk_div_8  - clk_in / 8,  50% duty
//   clk_div_16 - clk_in / 16, 50% duty
module clock_div_two (
  input  logic clk_in,
  input  logic rst,
  output logic clk_div_2,
  output logic clk_div_4,
  output logic clk_div_8,
  output logic clk_div_16
);

  localparam int NUM_STAGES = 4;

  logic [NUM_STAGES-1:0] w_cnt;
  logic [NUM_STAGES-1:0] w_toggle_en;

  // Stage k toggles when every lower bit is 1 (carry of a binary counter).
  // Each enable is a direct AND of stage outputs rather than a chain through
  // w_toggle_en, so no signal feeds back into its own vector.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_toggle_en[k] = 1'b1;
    end else begin : g_rest
      assign w_toggle_en[k] = &w_cnt[k-1:0];
    end

    clock_div_stage u_stage (
      .clk_in    (clk_in),
      .rst       (rst),
      .toggle_en (w_toggle_en[k]),
      .q         (w_cnt[k])
    );
  end

  assign clk_div_2  = w_cnt[0];
  assign clk_div_4  = w_cnt[1];
  assign clk_div_8  = w_cnt[2];
  assign clk_div_16 = w_cnt[3];

endmodule

// File: tb/tb_clock_div_two.sv
// tb/tb_clock_div_two.sv - scoreboard testbench for clock_div_two
module tb_clock_div_two;

  localparam int HALF = 10;

  logic clk_in;
  logic rst;
  logic clk_div_2;
  logic clk_div_4;
  logic clk_div_8;
  logic clk_div_16;

  clock_div_two dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .clk_div_2  (clk_div_2),
    .clk_div_4  (clk_div_4),
    .clk_div_8  (clk_div_8),
    .clk_div_16 (clk_div_16)
  );

  initial clk_in = 1'b0;
  always #(HALF) clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [3:0] val;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;

  wire [3:0] dv = {clk_div_16, clk_div_8, clk_div_4, clk_div_2};

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops and compares every expectation whenever a sample is presented.
  initial begin
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (dv !== e.val) begin
          errors++;
          $display("FAIL %s: got %b expected %b at t=%0t", e.name, dv, e.val, $time);
        end
      end
    end
  end

  // Edge alignment and period/high-time measurement.
  int     align_errs = 0;
  logic [3:0] prev_dv = 4'b0000;
  longint last_rise [4] = '{-1, -1, -1, -1};
  longint per_t     [4] = '{0, 0, 0, 0};
  longint high_t    [4] = '{0, 0, 0, 0};

  always @(dv) begin
    if ($time > 0 && rst === 1'b1) begin
      if (clk_in !== 1'b1) align_errs++;
      for (int k = 0; k < 4; k++) begin
        if (dv[k] === 1'b1 && prev_dv[k] === 1'b0) begin
          if (last_rise[k] >= 0) per_t[k] = $time - last_rise[k];
          last_rise[k] = $time;
        end else if (dv[k] === 1'b0 && prev_dv[k] === 1'b1 && last_rise[k] >= 0) begin
          high_t[k] = $time - last_rise[k];
        end
      end
    end
    prev_dv = dv;
  end

  task automatic push(input string name, input logic [3:0] v);
    exp_t e;
    e.name = name;
    e.val  = v;
    exp_q.push_back(e);
    -> sample_ev;
  endtask

  logic [3:0] exp_cnt;

  initial begin
    rst = 1'b0;
    exp_cnt = 4'd0;

    // Reset held: edges ignored, outputs stay 0.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_in); #1;
      push("reset_hold", 4'b0000);
    end

    // Release between edges, then 16 edges including the 15->0 wrap.
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk_in); #1;
      exp_cnt = exp_cnt + 4'd1;
      push($sformatf("count_edge%0d", i + 1), exp_cnt);
    end

    // Before the wrap edge the counter must sit at 1111, then fall together.
    for (int i = 0; i < 15; i++) begin
      @(posedge clk_in); #1;
      exp_cnt = exp_cnt + 4'd1;
      push("pre_wrap", exp_cnt);
    end
    @(negedge clk_in);
    push("wrap_before", 4'b1111);
    @(posedge clk_in); #1;
    exp_cnt = exp_cnt + 4'd1;
    push("wrap_after", 4'b0000);

    // 64 further cycles for period measurement.
    for (int i = 0; i < 64; i++) begin
      @(posedge clk_in); #1;
      exp_cnt = exp_cnt + 4'd1;
      push("run", exp_cnt);
    end

    for (int k = 0; k < 4; k++) begin
      chk($sformatf("period_div%0d", 2 << k), per_t[k], longint'((4 * HALF) << k));
      chk($sformatf("high_div%0d", 2 << k), high_t[k], longint'((2 * HALF) << k));
    end
    chk("edge_alignment_errs", align_errs, 0);

    // Mid-cycle reset when cnt = 0110, 5 time units after the edge.
    while (exp_cnt != 4'b0110) begin
      @(posedge clk_in); #1;
      exp_cnt = exp_cnt + 4'd1;
      push("to_0110", exp_cnt);
    end
    #4;
    rst = 1'b0;
    #1;
    push("midreset_immediate", 4'b0000);
    @(posedge clk_in); #1;
    push("midreset_edge_ignored", 4'b0000);
    rst = 1'b1;
    @(posedge clk_in); #1;
    push("restart_first_edge", 4'b0001);
    @(posedge clk_in); #1;
    push("restart_second_edge", 4'b0010);

    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_div_two.md
Name: clock_div_two

Overview:
Power-of-two clock divider. Derives four divided clocks (/2, /4, /8, /16) from one input clock. All outputs are retimed to the same clk_in rising edge, so they are mutually phase-aligned with no ripple skew. Sits at the clocking front of the design and feeds slower logic and display refresh domains.

Parameters:
NUM_STAGES, 4, number of divide-by-2 stages; fixed at 4 for this port list; localparam, not overridable.

Ports:
clk_in  input  1  source clock; all state updates on its rising edge
rst  input  1  asynchronous, active-low reset; 0 = reset asserted
clk_div_2  output  1  clk_in / 2, 50% duty
clk_div_4  output  1  clk_in / 4, 50% duty
clk_div_8  output  1  clk_in / 8, 50% duty
clk_div_16  output  1  clk_in / 16, 50% duty

Behaviour:
- One clock, one reset. Interface is fixed: one clock; reset is asynchronous and active-low.
- State is a 4-bit up-counter cnt[3:0]. Outputs are direct register bits: clk_div_2=cnt[0], clk_div_4=cnt[1], clk_div_8=cnt[2], clk_div_16=cnt[3]. No combinational logic on outputs.
- Reset: rst=0 forces cnt=0 immediately, without waiting for a clock edge. All four outputs are 0 while rst=0. clk_in edges during reset are ignored.
- Release: after rst goes to 1, the first clk_in rising edge sets cnt=1, so clk_div_2 rises on that edge. Latency from the first active edge to an output change is one edge, with no pipeline.
- Counting: cnt increments by 1 on every clk_in rising edge while rst=1. It wraps from 15 to 0 with no glitch and no held state.
- Stage k (k=0..3) toggles on a clk_in rising edge when all lower bits cnt[k-1:0] are 1. Stage 0 toggles on every edge.
- Periods: clk_div_2N has a period of 2N clk_in cycles and is high for exactly N cycles.
- All output edges coincide with clk_in rising edges. Simultaneous transitions are expected; for example, at 7->8 cnt[3] rises while cnt[2:0] fall on the same edge.
- Reset mid-operation: asserting rst at any point, including between edges, clears all outputs at once. Restarting follows the release rule above.
- Deassertion is not synchronized internally. The system reset controller releases rst synchronously to clk_in.
- No enable, no handshake, no status outputs.

Decomposition:
- No shared package needed. NUM_STAGES is a local constant.
- One natural sub-module: clock_div_stage. It is a single toggle flop with inputs clk_in, rst and toggle_en, and output q, which resets to 0.
- Instantiate it 4 times in a generate loop. Stage k's toggle_en is the AND of stages 0..k-1; stage 0 has toggle_en=1.

Test Plan:
- Hold rst=0 for 5 clk_in cycles (20 ns period) -> all four outputs 0 throughout; no toggling.
- Release rst=1, then apply 16 rising edges -> after each edge, {clk_div_16,clk_div_8,clk_div_4,clk_div_2} = 0001, 0010, ... 1111, then 0000 on the 16th.
- Run 64 cycles and measure periods -> clk_div_2 = 40 ns, clk_div_4 = 80 ns, clk_div_8 = 160 ns, clk_div_16 = 320 ns. Each output is high for exactly half its period.
- Assert rst=0 mid-cycle when cnt=0110 (5 ns after an edge) -> all outputs read 0 before the next clk_in edge.
- Check the wrap edge after the 15th post-reset edge (cnt=1111) -> on the next edge, all four outputs fall on the same edge with no intermediate values.
- Check edge alignment -> every output transition occurs at a clk_in rising edge and never at a falling edge.
